// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, the divisor helper used by both
// the transmit and receive sides, and the transmit engine state encoding.
package uart_pkg;

   localparam int DEF_CLK_FREQ_HZ = 32'sd50_000_000;
   localparam int DEF_BAUD        = 32'sd115_200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int baud_div(input int clk_freq_hz, input int baud);
      return clk_freq_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte buffer between the bus handshake and the transmit engine;
// occupancy lives in the extra level bit so the pointers wrap freely.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   sclk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (level_r == LVL_FULL);
   assign empty_s   = (level_r == {(AW+1){1'b0}});
   assign push_ok_s = push && !full_s;
   assign pop_ok_s  = pop && !empty_s;

   assign full  = full_s;
   assign empty = empty_s;
   assign level = level_r;
   assign dout  = mem_r[rd_ptr_r];

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge sclk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the level.
   always_ff @(posedge sclk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 console transmitter: buffers bus bytes and shifts them LSB-first onto
// rs232_tx, chaining frames with no idle gap while the buffer holds data.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int BAUD        = DEF_BAUD,
   parameter int BAUD_DIV    = baud_div(CLK_FREQ_HZ, BAUD),
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                        sclk,
   input  logic                        reset,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        rs232_tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 32'sd1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1'b1);
   localparam logic          STOP_LAST = (STOP_BITS == 32'sd2) ? 1'b1 : 1'b0;

   uart_state_e   state_r;
   uart_state_e   state_next_s;
   logic [BW-1:0] baud_cnt_r;
   logic [BW-1:0] baud_cnt_next_s;
   logic [2:0]    bit_idx_r;
   logic [2:0]    bit_idx_next_s;
   logic          stop_idx_r;
   logic          stop_idx_next_s;
   logic [7:0]    sh_r;
   logic [7:0]    sh_next_s;
   logic          tx_r;
   logic          tx_next_s;
   logic          busy_r;
   logic          busy_next_s;
   logic          baud_last_s;
   logic          push_s;
   logic          pop_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [7:0]    fifo_dout_s;
   logic [LW-1:0] fifo_level_s;

   assign tx_ready    = !fifo_full_s && !reset;
   assign push_s      = tx_valid && tx_ready;
   assign baud_last_s = (baud_cnt_r == BAUD_LAST);

   assign rs232_tx   = tx_r;
   assign tx_busy    = busy_r;
   assign fifo_level = fifo_level_s;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sclk  (sclk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (tx_data),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   // Next-state, bit timing and line level; the line register lags the state by one cycle.
   always_comb begin
      state_next_s    = state_r;
      baud_cnt_next_s = baud_cnt_r;
      bit_idx_next_s  = bit_idx_r;
      stop_idx_next_s = stop_idx_r;
      sh_next_s       = sh_r;
      pop_s           = 1'b0;
      tx_next_s       = 1'b1;
      case (state_r)
         IDLE: begin
            tx_next_s       = 1'b1;
            baud_cnt_next_s = {BW{1'b0}};
            if (!fifo_empty_s) begin
               pop_s        = 1'b1;
               sh_next_s    = fifo_dout_s;
               state_next_s = START;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            tx_next_s = 1'b0;
            if (baud_last_s) begin
               baud_cnt_next_s = {BW{1'b0}};
               bit_idx_next_s  = 3'd0;
               state_next_s    = DATA;
            end else begin
               baud_cnt_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         DATA: begin
            tx_next_s = sh_r[bit_idx_r];
            if (baud_last_s) begin
               baud_cnt_next_s = {BW{1'b0}};
               if (bit_idx_r == 3'd7) begin
                  stop_idx_next_s = 1'b0;
                  state_next_s    = STOP;
               end else begin
                  bit_idx_next_s = bit_idx_r + 3'd1;
               end
            end else begin
               baud_cnt_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         STOP: begin
            tx_next_s = 1'b1;
            if (baud_last_s) begin
               baud_cnt_next_s = {BW{1'b0}};
               if (stop_idx_r == STOP_LAST) begin
                  // Chain straight into the next start bit when more data is waiting.
                  if (!fifo_empty_s) begin
                     pop_s        = 1'b1;
                     sh_next_s    = fifo_dout_s;
                     state_next_s = START;
                  end else begin
                     state_next_s = IDLE;
                  end
               end else begin
                  stop_idx_next_s = stop_idx_r + 1'b1;
               end
            end else begin
               baud_cnt_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         default: begin
            state_next_s    = IDLE;
            baud_cnt_next_s = {BW{1'b0}};
         end
      endcase
      busy_next_s = (state_r != IDLE) || (state_next_s != IDLE);
   end

   // Engine state and output registers.
   always_ff @(posedge sclk) begin
      if (reset) begin
         state_r    <= IDLE;
         baud_cnt_r <= {BW{1'b0}};
         bit_idx_r  <= 3'd0;
         stop_idx_r <= 1'b0;
         sh_r       <= 8'h00;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         baud_cnt_r <= baud_cnt_next_s;
         bit_idx_r  <= bit_idx_next_s;
         stop_idx_r <= stop_idx_next_s;
         sh_r       <= sh_next_s;
         tx_r       <= tx_next_s;
         busy_r     <= busy_next_s;
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: the transmit side of the board's RS-232 console link.
- Accepts bytes from the on-chip bus master through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte LSB-first onto rs232_tx at a fixed baud derived from the system clock.
- Back-to-back frames leave the line with no idle gap, so the host-side receiver sees continuous traffic at full rate.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency on sclk.
- BAUD, 115200, line rate.
- BAUD_DIV, CLK_FREQ_HZ/BAUD (434), sclk cycles per bit; integer division. Overridable for simulation; minimum 4.
- STOP_BITS, 1, number of stop bits; 1 or 2 only.
- FIFO_DEPTH, 16, byte buffer depth; power of two, at least 2.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte; a transfer occurs when tx_valid && tx_ready at a rising edge.
- rs232_tx  out  1  serial line; idles high; registered output.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte currently shifting.

Behaviour:
- Reset (sclk edge with reset=1) forces:
  - rs232_tx=1, tx_busy=0, fifo_level=0, FIFO emptied, state IDLE, baud/bit counters 0.
  - tx_ready is 0 while reset is high and 1 on the first cycle after release.
- Reset mid-frame aborts the frame: rs232_tx returns high at that edge and no partial byte is resumed.
- FIFO:
  - tx_ready = !full.
  - A push when full is impossible; a push coinciding with a pop while full is still refused (ready already low).
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH; occupancy is held in the extra level bit.
- Engine states and transitions:
  - IDLE: rs232_tx=1. If FIFO non-empty, pop the head into shift register sh[7:0] and go to START.
  - START: rs232_tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: rs232_tx=sh[idx] for BAUD_DIV cycles per bit, idx 0..7 (LSB first). After idx 7 go to STOP.
  - STOP: rs232_tx=1 for STOP_BITS*BAUD_DIV cycles. On the last cycle, if FIFO non-empty, pop and go to START directly (no idle gap); else go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and wraps; its width is $clog2(BAUD_DIV). It holds 0 in IDLE.
- Latency:
  - A byte accepted at edge k into an empty FIFO with the engine idle is popped at edge k+1.
  - rs232_tx goes low at edge k+2.
- Frame length is exactly (9+STOP_BITS)*BAUD_DIV cycles, measured from the start-bit falling edge to the end of the stop bit.
- tx_busy is registered. It rises at edge k+1 and falls on the cycle after the final stop bit when the FIFO is empty.
- The FIFO accepts bytes while a frame is in progress; accepted data is never dropped or reordered.

Decomposition:
- Shared package uart_pkg holds:
  - CLK_FREQ_HZ and BAUD defaults.
  - A BAUD_DIV computation function, shared with the receive side so both ends agree.
  - The engine state encoding: IDLE, START, DATA, STOP.
- Sub-module uart_tx_fifo: synchronous single-clock FIFO (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level). Its reset is identical to the top's.
- The top contains the engine only.

Test Plan:
- BAUD_DIV=8, send 0x55 -> rs232_tx low at k+2 for 8 cycles, then the pattern 1,0,1,0,1,0,1,0 at 8 cycles each, then high for 8 cycles. Total 80 cycles. tx_busy falls afterwards.
- BAUD_DIV=8, push 0xA5 then 0x3C on consecutive cycles -> two contiguous 80-cycle frames with no high gap between the stop bit and the second start bit. Bits are LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- BAUD_DIV=8, hold tx_valid with 20 bytes 0x00..0x13 -> tx_ready drops once fifo_level=16 (one byte shifting). All 20 bytes are emitted in order; ready recovers after each pop.
- BAUD_DIV=8, STOP_BITS=2, send 0xFF -> start bit of 8 cycles, then rs232_tx high for 80 cycles. Frame length is 88 cycles.
- BAUD_DIV=8, assert reset for one cycle during bit 3 of 0x0F with 3 bytes queued -> rs232_tx=1 at that edge, fifo_level=0, tx_busy=0, and no further frames. A new byte 0x81 then transmits correctly.
- Default parameters (434), loop rs232_tx into the team's receiver, send 0x00, 0xFF, 0x81 -> receiver reports the same three bytes in order with one completion pulse each.
